// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: decodes the IR, sequences the datapath and
// waits on a mem_ready handshake with an optional timeout into a sticky TRAP.
module mc_controller #(
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter bit ENABLE_JAL   = 1'b1,
    parameter bit ENABLE_BNE   = 1'b1,
    parameter int WAIT_LIMIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        PCWriteCondition,
    output logic        BranchNE,
    output logic        PCWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic [1:0]  PCSource,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic        instr_done,
    output logic        trap,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        EXEC_I = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } stateT;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    stateT       stateReg;
    stateT       stateNext;
    logic [7:0]  waitCntReg;
    logic [7:0]  waitCntNext;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        isWaitState;
    logic        limitHit;
    logic        branchLegal;
    logic        unusedInstrBits;

    assign opcode          = instr[6:0];
    assign funct3          = instr[14:12];
    assign unusedInstrBits = ^{instr[31:15], instr[11:7]};
    assign branchLegal     = (funct3 == 3'b000) || ((funct3 == 3'b001) && ENABLE_BNE);
    assign isWaitState     = (stateReg == FETCH) || (stateReg == MEMRD) || (stateReg == MEMWR);

    // A zero limit removes the timeout path entirely.
    generate
        if (WAIT_LIMIT == 0) begin : gen_no_limit
            assign limitHit = 1'b0;
        end else begin : gen_limit
            assign limitHit = (waitCntReg == 8'(WAIT_LIMIT));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= FETCH;
            waitCntReg <= 8'd0;
        end else begin
            stateReg   <= stateNext;
            waitCntReg <= waitCntNext;
        end
    end

    // Any state change clears the counter, so it starts at 0 in every wait state.
    always_comb begin
        waitCntNext = waitCntReg;
        if (stateNext != stateReg) begin
            waitCntNext = 8'd0;
        end else if (isWaitState && !mem_ready && (waitCntReg != 8'hFF)) begin
            waitCntNext = waitCntReg + 8'd1;
        end
    end

    always_comb begin
        stateNext        = stateReg;
        PCWriteCondition = 1'b0;
        BranchNE         = 1'b0;
        PCWrite          = 1'b0;
        IorD             = 1'b0;
        MemRead          = 1'b0;
        MemWrite         = 1'b0;
        IRWrite          = 1'b0;
        ALUSrcA          = 1'b0;
        RegWrite         = 1'b0;
        PCSource         = 2'b00;
        MemtoReg         = 2'b00;
        ALUOp            = 2'b00;
        ALUSrcB          = 2'b00;
        instr_done       = 1'b0;
        trap             = 1'b0;

        case (stateReg)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)     stateNext = DECODE;
                else if (limitHit) stateNext = TRAP;
            end
            DECODE: begin
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_LOAD, OP_STORE: stateNext = MEMADR;
                    OP_RTYPE:          stateNext = EXEC_R;
                    OP_ITYPE:          stateNext = ENABLE_ITYPE ? EXEC_I : TRAP;
                    OP_BRANCH:         stateNext = branchLegal ? BRANCH : TRAP;
                    OP_JAL:            stateNext = ENABLE_JAL ? JAL : TRAP;
                    default:           stateNext = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                stateNext = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)     stateNext = MEMWB;
                else if (limitHit) stateNext = TRAP;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready)     stateNext = FETCH;
                else if (limitHit) stateNext = TRAP;
            end
            EXEC_R: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                stateNext = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b11;
                stateNext = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            BRANCH: begin
                ALUSrcA          = 1'b1;
                ALUOp            = 2'b01;
                PCWriteCondition = 1'b1;
                PCSource         = 2'b01;
                BranchNE         = instr[12];
                instr_done       = 1'b1;
                stateNext        = FETCH;
            end
            JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b01;
                RegWrite   = 1'b1;
                MemtoReg   = 2'b10;
                instr_done = 1'b1;
                stateNext  = FETCH;
            end
            TRAP: begin
                trap      = 1'b1;
                stateNext = TRAP;
            end
            default: begin
                trap      = 1'b1;
                stateNext = TRAP;
            end
        endcase

        // Reset overrides anything that could commit architectural state.
        if (rst) begin
            PCWrite          = 1'b0;
            PCWriteCondition = 1'b0;
            MemWrite         = 1'b0;
            RegWrite         = 1'b0;
            IRWrite          = 1'b0;
            instr_done       = 1'b0;
        end
    end

    assign state = stateReg;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a default instance runs instruction
// sequences cycle by cycle; a second instance covers disabled jal and timeout.
module tb_mc_controller;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    localparam logic [31:0] I_LW   = 32'h00C12283;
    localparam logic [31:0] I_SW   = 32'h007B2823;
    localparam logic [31:0] I_SUB  = 32'h41F481B3;
    localparam logic [31:0] I_ADDI = 32'h00A30293;
    localparam logic [31:0] I_BEQ  = 32'hFEB408E3;
    localparam logic [31:0] I_BNE  = 32'hFEB418E3;
    localparam logic [31:0] I_JAL  = 32'h0100006F;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       branchNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       aluSrcA;
        logic       regWrite;
        logic [1:0] pcSource;
        logic [1:0] memtoReg;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
        logic       instrDone;
        logic       trap;
    } ctlT;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        ctlT        ctl;
    } itemT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, memReady;
    logic [31:0] instr;
    logic        PCWriteCondition, BranchNE, PCWrite, IorD, MemRead, MemWrite;
    logic        IRWrite, ALUSrcA, RegWrite, instrDone, trap;
    logic [1:0]  PCSource, MemtoReg, ALUOp, ALUSrcB;
    logic [3:0]  state;
    ctlT         obs;

    mc_controller dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(memReady),
        .PCWriteCondition(PCWriteCondition), .BranchNE(BranchNE), .PCWrite(PCWrite),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .PCSource(PCSource), .MemtoReg(MemtoReg),
        .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .instr_done(instrDone), .trap(trap), .state(state)
    );

    always_comb obs = {PCWrite, PCWriteCondition, BranchNE, IorD, MemRead, MemWrite,
                       IRWrite, ALUSrcA, RegWrite, PCSource, MemtoReg, ALUOp, ALUSrcB,
                       instrDone, trap};

    // jal disabled, four-cycle memory timeout
    logic        rstB, memReadyB;
    logic [31:0] instrB;
    logic        pcwcB, bneB, pcwB, iordB, mrdB, mwrB, irwB, srcaB, rwB, doneB, trapB;
    logic [1:0]  pcsB, m2rB, aopB, srcbB;
    logic [3:0]  stateB;

    mc_controller #(.ENABLE_JAL(1'b0), .WAIT_LIMIT(4)) dutB (
        .clk(clk), .rst(rstB), .instr(instrB), .mem_ready(memReadyB),
        .PCWriteCondition(pcwcB), .BranchNE(bneB), .PCWrite(pcwB), .IorD(iordB),
        .MemRead(mrdB), .MemWrite(mwrB), .IRWrite(irwB), .ALUSrcA(srcaB), .RegWrite(rwB),
        .PCSource(pcsB), .MemtoReg(m2rB), .ALUOp(aopB), .ALUSrcB(srcbB),
        .instr_done(doneB), .trap(trapB), .state(stateB)
    );

    int   checks = 0;
    int   passes = 0;
    itemT sb[$];

    // Expected control word for one state, written from the state table.
    function automatic ctlT expCtl(logic [3:0] s, logic mr, logic b12);
        ctlT c = '0;
        case (s)
            S_FETCH:  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = mr; c.pcWrite = mr; end
            S_DECODE: begin c.aluSrcB = 2'b10; end
            S_MEMADR: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            S_MEMRD:  begin c.memRead = 1; c.iorD = 1; end
            S_MEMWB:  begin c.regWrite = 1; c.memtoReg = 2'b01; c.instrDone = 1; end
            S_MEMWR:  begin c.memWrite = 1; c.iorD = 1; c.instrDone = mr; end
            S_EXECR:  begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            S_EXECI:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluOp = 2'b11; end
            S_ALUWB:  begin c.regWrite = 1; c.instrDone = 1; end
            S_BRANCH: begin
                c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01;
                c.branchNe = b12; c.instrDone = 1;
            end
            S_JAL:    begin
                c.pcWrite = 1; c.pcSource = 2'b01; c.regWrite = 1; c.memtoReg = 2'b10;
                c.instrDone = 1;
            end
            default:  begin c.trap = 1; end
        endcase
        return c;
    endfunction

    task automatic push(input logic [3:0] st, input logic mr);
        itemT it;
        it.st  = st;
        it.mr  = mr;
        it.ctl = expCtl(st, mr, instr[12]);
        sb.push_back(it);
    endtask

    // Entered and left just after a rising edge; one queue item per cycle.
    task automatic drain(input string name);
        int n = 0;
        int bad = 0;
        while (sb.size() > 0) begin
            itemT it = sb.pop_front();
            memReady = it.mr;
            @(negedge clk);
            checks++;
            if (state !== it.st) begin
                $display("FAIL %s step %0d state: got %0d expected %0d", name, n, state, it.st);
                bad++;
            end else passes++;
            checks++;
            if (obs !== it.ctl) begin
                $display("FAIL %s step %0d ctl: got %05h expected %05h", name, n, obs, it.ctl);
                bad++;
            end else passes++;
            n++;
            @(posedge clk);
            #1;
        end
        $display("txn %-12s instr=%08h cycles=%0d errors=%0d", name, instr, n, bad);
    endtask

    task automatic test_reset();
        rst = 1; memReady = 1; instr = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== S_FETCH) $display("FAIL reset_state: got %0d expected 0", state);
        else passes++;
        checks++;
        if ({PCWrite, IRWrite, instrDone, trap} !== 4'b0000)
            $display("FAIL reset_forced: got %b expected 0000", {PCWrite, IRWrite, instrDone, trap});
        else passes++;
        @(posedge clk); #1;
        rst = 0;
        $display("txn reset done");
    endtask

    task automatic test_lw();
        instr = I_LW;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1); push(S_MEMRD, 1); push(S_MEMWB, 1);
        drain("lw");
    endtask

    task automatic test_sw_wait();
        instr = I_SW;
        push(S_FETCH, 1); push(S_DECODE, 0); push(S_MEMADR, 0);
        push(S_MEMWR, 0); push(S_MEMWR, 0); push(S_MEMWR, 0); push(S_MEMWR, 1);
        drain("sw_wait");
    endtask

    task automatic test_r_i();
        instr = I_SUB;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECR, 1); push(S_ALUWB, 1);
        drain("sub");
        instr = I_ADDI;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_EXECI, 1); push(S_ALUWB, 1);
        drain("addi");
    endtask

    task automatic test_branch();
        instr = I_BEQ;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_BRANCH, 1);
        drain("beq");
        instr = I_BNE;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_BRANCH, 0);
        drain("bne");
    endtask

    task automatic test_jal();
        instr = I_JAL;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_JAL, 1);
        drain("jal");
    endtask

    task automatic test_back_to_back_waits();
        instr = I_ADDI;
        push(S_FETCH, 0); push(S_FETCH, 0); push(S_FETCH, 0); push(S_FETCH, 1);
        push(S_DECODE, 1); push(S_EXECI, 0); push(S_ALUWB, 0);
        drain("addi_fwait");
        instr = I_LW;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1);
        push(S_MEMRD, 0); push(S_MEMRD, 0); push(S_MEMRD, 1); push(S_MEMWB, 0);
        drain("lw_rdwait");
    endtask

    task automatic test_rst_mid();
        instr = I_LW;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_MEMADR, 1);
        drain("lw_partial");
        rst = 1; memReady = 1;
        @(negedge clk);
        checks++;
        if (state !== S_MEMRD) $display("FAIL rst_mid_pre: got %0d expected 3", state);
        else passes++;
        @(posedge clk); #1;
        rst = 0; memReady = 0;
        @(negedge clk);
        checks++;
        if (state !== S_FETCH) $display("FAIL rst_mid_state: got %0d expected 0", state);
        else passes++;
        checks++;
        if ({PCWrite, PCWriteCondition, MemWrite, RegWrite, IRWrite, instrDone} !== 6'b0)
            $display("FAIL rst_mid_enables: got %b expected 000000",
                     {PCWrite, PCWriteCondition, MemWrite, RegWrite, IRWrite, instrDone});
        else passes++;
        @(posedge clk); #1;
        $display("txn rst_mid done");
    endtask

    task automatic test_illegal();
        instr = I_ILL;
        push(S_FETCH, 1); push(S_DECODE, 1); push(S_TRAP, 1); push(S_TRAP, 0); push(S_TRAP, 1);
        drain("illegal");
        rst = 1; memReady = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if ({state, trap} !== {S_FETCH, 1'b0})
            $display("FAIL illegal_recover: got state=%0d trap=%b expected state=0 trap=0", state, trap);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic checkB(input string name, input logic [3:0] expSt, input logic expTrap);
        checks++;
        if ({stateB, trapB, doneB} !== {expSt, expTrap, 1'b0})
            $display("FAIL %s: got state=%0d trap=%b done=%b expected state=%0d trap=%b done=0",
                     name, stateB, trapB, doneB, expSt, expTrap);
        else passes++;
    endtask

    task automatic test_jal_disabled();
        instrB = I_JAL; memReadyB = 1; rstB = 1;
        @(posedge clk); #1;
        rstB = 0;
        checkB("jal_dis_fetch", S_FETCH, 1'b0);
        @(posedge clk); #1;
        checkB("jal_dis_decode", S_DECODE, 1'b0);
        @(posedge clk); #1;
        checkB("jal_dis_trap", S_TRAP, 1'b1);
        for (int i = 0; i < 3; i++) begin
            memReadyB = ~memReadyB;
            @(posedge clk); #1;
            checkB("jal_dis_sticky", S_TRAP, 1'b1);
        end
        rstB = 1;
        @(posedge clk); #1;
        checkB("jal_dis_reset", S_FETCH, 1'b0);
        $display("txn jal_disabled done");
    endtask

    task automatic test_wait_limit();
        instrB = I_LW; memReadyB = 0; rstB = 1;
        @(posedge clk); #1;
        rstB = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkB("fetch_waiting", S_FETCH, 1'b0);
        end
        @(posedge clk); #1;
        checkB("fetch_timeout", S_TRAP, 1'b1);

        rstB = 1;
        @(posedge clk); #1;
        rstB = 0;
        repeat (4) @(posedge clk);
        #1;
        memReadyB = 1;
        @(posedge clk); #1;
        checkB("limit_ready_wins", S_DECODE, 1'b0);
        memReadyB = 0;
        @(posedge clk); #1;
        checkB("rd_memadr", S_MEMADR, 1'b0);
        @(posedge clk); #1;
        checkB("rd_enter", S_MEMRD, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checkB("rd_waiting", S_MEMRD, 1'b0);
        @(posedge clk); #1;
        checkB("rd_timeout", S_TRAP, 1'b1);
        $display("txn wait_limit done");
    endtask

    initial begin
        rstB = 1; memReadyB = 0; instrB = 32'h0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_r_i();
        test_branch();
        test_jal();
        test_back_to_back_waits();
        test_rst_mid();
        test_illegal();
        memReady = 0;
        test_jal_disabled();
        test_wait_limit();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
